// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: main entry plus optional skid entry, with flush, bubble squash and stall counter.
// Latency: 1 cycle from input transfer to out_valid. Backpressure: SKID=1 registered in_ready (skid absorbs one), SKID=0 combinational in_ready.
// Backpressure: out_ready low holds the head; upstream stalls once the stage is full.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_data_read,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_data_read,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] data_read;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           in_ent;
    logic [CNT_W-1:0] stall_q;
    logic             main_v;
    logic             skid_v;
    logic             accept;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid_in;

    assign in_ent = {in_alu_result, in_data_read, in_rd, in_ctrl};
    assign main_v = (state_q != ST_EMPTY);
    assign skid_v = (state_q == ST_FULL);

    // With a skid entry, in_ready is a pure decode of the state register.
    generate
        if (SKID != 0) begin : g_skid_rdy
            assign in_ready = !skid_v;
        end else begin : g_single_rdy
            assign in_ready = !main_v || out_ready;
        end
    endgenerate

    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt      = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt    = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept) begin
                        // Without a skid entry, accepting while full implies the head is leaving.
                        if (out_ready || (SKID == 0)) begin
                            load_main_in = 1'b1;
                        end else begin
                            state_nxt    = ST_FULL;
                            load_skid_in = 1'b1;
                        end
                    end else if (out_ready) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_nxt      = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (load_main_in) begin
                main_q <= in_ent;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_ent;
            end
            if (main_v && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    // Payload holds while invalid; only rd and ctrl are squashed so bubbles carry no side effects.
    assign out_valid      = main_v;
    assign out_alu_result = main_q.alu_result;
    assign out_data_read  = main_q.data_read;
    assign out_rd         = main_v ? main_q.rd : '0;
    assign out_ctrl       = main_v ? main_q.ctrl : '0;
    assign stall_count    = stall_q;

endmodule
